// File: rtl/id_pkg.sv
// id_pkg: shared encodings for the pipelined ARM decode stage.
// Holds instruction mode/opcode constants, EX command encodings, condition
// codes, the ID/EX control bundle type and the decode/condition helpers.
package id_pkg;

    localparam logic [1:0] MODE_ARITH  = 2'b00;
    localparam logic [1:0] MODE_MEM    = 2'b01;
    localparam logic [1:0] MODE_BRANCH = 2'b10;

    // Data-processing opcodes (instruction bits [24:21])
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_TST = 4'b1000;

    // EX stage command encodings
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_CMP = 4'b0100;
    localparam logic [3:0] EXE_TST = 4'b0110;
    localparam logic [3:0] EXE_LDR = 4'b0010;
    localparam logic [3:0] EXE_STR = 4'b0010;

    // Condition codes (instruction bits [31:28])
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    typedef struct packed {
        logic [3:0] exe_cmd;
        logic       s;
        logic       b;
        logic       mem_w;
        logic       mem_r;
        logic       wb;
    } ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = 9'b0;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Condition check against NZCV; the reserved code 4'b1111 never executes.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        logic pass;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

    // Control bundle for one instruction; S only matters for data processing,
    // unknown opcodes and mode 2'b11 decode to an all-zero bundle.
    function automatic ctrl_t decode_ctrl(input logic [1:0] mode, input logic [3:0] opcode,
                                          input logic s_bit);
        ctrl_t c;
        c = BUBBLE_CTRL;
        case (mode)
            MODE_ARITH: begin
                c.s = s_bit;
                case (opcode)
                    OP_MOV: begin c.exe_cmd = EXE_MOV; c.wb = 1'b1; end
                    OP_MVN: begin c.exe_cmd = EXE_MVN; c.wb = 1'b1; end
                    OP_ADD: begin c.exe_cmd = EXE_ADD; c.wb = 1'b1; end
                    OP_ADC: begin c.exe_cmd = EXE_ADC; c.wb = 1'b1; end
                    OP_SUB: begin c.exe_cmd = EXE_SUB; c.wb = 1'b1; end
                    OP_SBC: begin c.exe_cmd = EXE_SBC; c.wb = 1'b1; end
                    OP_AND: begin c.exe_cmd = EXE_AND; c.wb = 1'b1; end
                    OP_ORR: begin c.exe_cmd = EXE_ORR; c.wb = 1'b1; end
                    OP_EOR: begin c.exe_cmd = EXE_EOR; c.wb = 1'b1; end
                    OP_CMP: c.exe_cmd = EXE_CMP;
                    OP_TST: c.exe_cmd = EXE_TST;
                    default: c = BUBBLE_CTRL;
                endcase
            end
            MODE_MEM: begin
                if (s_bit) begin
                    c.exe_cmd = EXE_LDR;
                    c.mem_r   = 1'b1;
                    c.wb      = 1'b1;
                end else begin
                    c.exe_cmd = EXE_STR;
                    c.mem_w   = 1'b1;
                end
            end
            MODE_BRANCH: c.b = 1'b1;
            default: c = BUBBLE_CTRL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/reg_file_param.sv
// reg_file_param: architectural register file, two async reads, one sync write.
// Indices >= REG_COUNT are not backed: writes are dropped, reads return 0.
// Optional macro WB_BYPASS_EN forwards a same-cycle write to the read ports.
module reg_file_param
    import id_pkg::*;
#(
    parameter int N         = 32,
    parameter int REG_COUNT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [3:0]   wr_idx,
    input  logic [N-1:0] wr_data,
    input  logic [3:0]   rd_idx1,
    input  logic [3:0]   rd_idx2,
    output logic [N-1:0] rd_data1,
    output logic [N-1:0] rd_data2
);

    logic [N-1:0] regs_r [16];
    logic         byp1_s;
    logic         byp2_s;

    function automatic logic idx_ok(input logic [3:0] idx);
        return {1'b0, idx} < 5'(REG_COUNT);
    endfunction

    // Register storage: cleared on reset, written on the rising edge
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                regs_r[i] <= {N{1'b0}};
            end
        end else if (we && idx_ok(wr_idx)) begin
            regs_r[wr_idx] <= wr_data;
        end
    end

`ifdef WB_BYPASS_EN
    assign byp1_s = we && (wr_idx == rd_idx1);
    assign byp2_s = we && (wr_idx == rd_idx2);
`else
    assign byp1_s = 1'b0;
    assign byp2_s = 1'b0;
`endif

    assign rd_data1 = !idx_ok(rd_idx1) ? {N{1'b0}} : (byp1_s ? wr_data : regs_r[rd_idx1]);
    assign rd_data2 = !idx_ok(rd_idx2) ? {N{1'b0}} : (byp2_s ? wr_data : regs_r[rd_idx2]);

endmodule

// File: rtl/id_stage_pipelined.sv
// id_stage_pipelined: ARM decode stage that owns the ID/EX pipeline register.
// Decodes, condition-checks and reads operands; handles stall bubbles and a
// FLUSH_CYCLES-long squash after a taken branch. Optional macro WB_BYPASS_EN
// (in reg_file_param) forwards same-cycle write-back data to the operands.
module id_stage_pipelined
    import id_pkg::*;
#(
    parameter int N            = 32,
    parameter int REG_COUNT    = 16,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  instructionIn,
    input  logic [N-1:0] PCIn,
    input  logic         validIn,
    input  logic [3:0]   statusIn,
    input  logic         hazardIn,
    input  logic         flushIn,
    input  logic         WB_ENIn,
    input  logic [3:0]   WB_DestIn,
    input  logic [N-1:0] WB_ValueIn,
    output logic [3:0]   src1Out,
    output logic [3:0]   src2Out,
    output logic         Two_srcOut,
    output logic         stallOut,
    output logic         validOut,
    output logic [N-1:0] PCOut,
    output logic [N-1:0] Val_RnOut,
    output logic [N-1:0] Val_RmOut,
    output logic [3:0]   EXE_CMDOut,
    output logic         SOut,
    output logic         BOut,
    output logic         MEM_W_ENOut,
    output logic         MEM_R_ENOut,
    output logic         WB_ENOut,
    output logic         IOut,
    output logic [3:0]   DestOut,
    output logic [11:0]  shiftOperandOut,
    output logic [23:0]  Imm24Out
);

    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES) - 4'd1;
    localparam logic       MULTI_FLUSH  = (4'(FLUSH_CYCLES) > 4'd1);

    logic [1:0]   mode_s;
    logic [3:0]   opcode_s;
    logic         s_bit_s;
    logic         i_bit_s;
    logic         is_str_s;
    logic         cond_ok_s;
    ctrl_t        dec_ctrl_s;
    ctrl_t        ctrl_r;
    logic [N-1:0] val_rn_s;
    logic [N-1:0] val_rm_s;
    state_t       state_r;
    state_t       state_next_s;
    logic [3:0]   flush_cnt_r;
    logic [3:0]   flush_cnt_next_s;
    logic         load_bubble_s;

    assign mode_s     = instructionIn[27:26];
    assign opcode_s   = instructionIn[24:21];
    assign s_bit_s    = instructionIn[20];
    assign i_bit_s    = instructionIn[25];
    assign is_str_s   = (mode_s == MODE_MEM) && !s_bit_s;
    assign cond_ok_s  = cond_pass(instructionIn[31:28], statusIn);
    assign dec_ctrl_s = decode_ctrl(mode_s, opcode_s, s_bit_s);

    assign src1Out    = instructionIn[19:16];
    assign src2Out    = is_str_s ? instructionIn[15:12] : instructionIn[3:0];
    assign Two_srcOut = !i_bit_s || is_str_s;

    reg_file_param #(
        .N         (N),
        .REG_COUNT (REG_COUNT)
    ) u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .we       (WB_ENIn),
        .wr_idx   (WB_DestIn),
        .wr_data  (WB_ValueIn),
        .rd_idx1  (src1Out),
        .rd_idx2  (src2Out),
        .rd_data1 (val_rn_s),
        .rd_data2 (val_rm_s)
    );

    // Squash FSM state and remaining-cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_RUN;
            flush_cnt_r <= 4'd0;
        end else begin
            state_r     <= state_next_s;
            flush_cnt_r <= flush_cnt_next_s;
        end
    end

    // Next state: enter/extend squash on flushIn, leave it when the count runs out
    always_comb begin
        state_next_s     = state_r;
        flush_cnt_next_s = flush_cnt_r;
        case (state_r)
            ST_RUN: begin
                if (flushIn && MULTI_FLUSH) begin
                    state_next_s     = ST_FLUSH;
                    flush_cnt_next_s = FLUSH_RELOAD;
                end else begin
                    state_next_s     = ST_RUN;
                    flush_cnt_next_s = 4'd0;
                end
            end
            ST_FLUSH: begin
                if (flushIn) begin
                    state_next_s     = ST_FLUSH;
                    flush_cnt_next_s = FLUSH_RELOAD;
                end else if (flush_cnt_r <= 4'd1) begin
                    state_next_s     = ST_RUN;
                    flush_cnt_next_s = 4'd0;
                end else begin
                    state_next_s     = ST_FLUSH;
                    flush_cnt_next_s = flush_cnt_r - 4'd1;
                end
            end
            default: begin
                state_next_s     = ST_RUN;
                flush_cnt_next_s = 4'd0;
            end
        endcase
    end

    // Slot selection in priority order flush > squash > hazard; stall only on a real hazard hold
    always_comb begin
        load_bubble_s = 1'b0;
        stallOut      = 1'b0;
        if (flushIn) begin
            load_bubble_s = 1'b1;
        end else if (state_r == ST_FLUSH) begin
            load_bubble_s = 1'b1;
        end else if (hazardIn) begin
            load_bubble_s = 1'b1;
            stallOut      = 1'b1;
        end else begin
            load_bubble_s = 1'b0;
        end
    end

    // ID/EX pipeline register: reset or bubble clears everything, otherwise load the slot
    always_ff @(posedge clk) begin
        if (rst || load_bubble_s) begin
            validOut        <= 1'b0;
            ctrl_r          <= BUBBLE_CTRL;
            PCOut           <= {N{1'b0}};
            Val_RnOut       <= {N{1'b0}};
            Val_RmOut       <= {N{1'b0}};
            IOut            <= 1'b0;
            DestOut         <= 4'd0;
            shiftOperandOut <= 12'd0;
            Imm24Out        <= 24'd0;
        end else begin
            validOut        <= validIn;
            ctrl_r          <= (validIn && cond_ok_s) ? dec_ctrl_s : BUBBLE_CTRL;
            PCOut           <= PCIn;
            Val_RnOut       <= val_rn_s;
            Val_RmOut       <= val_rm_s;
            IOut            <= i_bit_s;
            DestOut         <= instructionIn[15:12];
            shiftOperandOut <= instructionIn[11:0];
            Imm24Out        <= instructionIn[23:0];
        end
    end

    assign EXE_CMDOut  = ctrl_r.exe_cmd;
    assign SOut        = ctrl_r.s;
    assign BOut        = ctrl_r.b;
    assign MEM_W_ENOut = ctrl_r.mem_w;
    assign MEM_R_ENOut = ctrl_r.mem_r;
    assign WB_ENOut    = ctrl_r.wb;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// tb_id_stage_pipelined: directed + random bench with a behavioural model.
// Model tracks a remaining-squash count and a plain register array.
module tb_id_stage_pipelined;

    localparam int N    = 32;
    localparam int REGS = 12;
    localparam int FC   = 3;

    logic        clk = 1'b0;
    logic        rst, validIn, hazardIn, flushIn, WB_ENIn;
    logic [31:0] instructionIn, PCIn, WB_ValueIn;
    logic [3:0]  statusIn, WB_DestIn;
    logic [3:0]  src1Out, src2Out, EXE_CMDOut, DestOut;
    logic        Two_srcOut, stallOut, validOut, SOut, BOut, MEM_W_ENOut, MEM_R_ENOut, WB_ENOut, IOut;
    logic [31:0] PCOut, Val_RnOut, Val_RmOut;
    logic [11:0] shiftOperandOut;
    logic [23:0] Imm24Out;

    int vectors     = 0;
    int miscompares = 0;
    int rem_prev    = 0;
    logic [31:0] rf_m [16];
    logic [3:0]  exe_tab [16];
    logic        wb_tab [16];
    logic        known_tab [16];

    id_stage_pipelined #(.N(N), .REG_COUNT(REGS), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .instructionIn(instructionIn), .PCIn(PCIn), .validIn(validIn),
        .statusIn(statusIn), .hazardIn(hazardIn), .flushIn(flushIn), .WB_ENIn(WB_ENIn),
        .WB_DestIn(WB_DestIn), .WB_ValueIn(WB_ValueIn), .src1Out(src1Out), .src2Out(src2Out),
        .Two_srcOut(Two_srcOut), .stallOut(stallOut), .validOut(validOut), .PCOut(PCOut),
        .Val_RnOut(Val_RnOut), .Val_RmOut(Val_RmOut), .EXE_CMDOut(EXE_CMDOut), .SOut(SOut),
        .BOut(BOut), .MEM_W_ENOut(MEM_W_ENOut), .MEM_R_ENOut(MEM_R_ENOut), .WB_ENOut(WB_ENOut),
        .IOut(IOut), .DestOut(DestOut), .shiftOperandOut(shiftOperandOut), .Imm24Out(Imm24Out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [3:0] op, input logic [3:0] exe, input logic wb);
        exe_tab[op]   = exe;
        wb_tab[op]    = wb;
        known_tab[op] = 1'b1;
    endtask

    // NZCV test: pairs of codes share a base test, odd code is the negation; 1111 never runs
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic base;
        case (c[3:1])
            3'd0: base = f[2];
            3'd1: base = f[1];
            3'd2: base = f[3];
            3'd3: base = f[0];
            3'd4: base = f[1] && !f[2];
            3'd5: base = (f[3] == f[0]);
            3'd6: base = !f[2] && (f[3] == f[0]);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return base ^ c[0];
    endfunction

    // {exe_cmd, S, B, MEM_W, MEM_R, WB}
    function automatic logic [8:0] ref_ctrl(input logic [31:0] ins);
        logic [3:0] op;
        op = ins[24:21];
        if (ins[27:26] == 2'b00) begin
            if (!known_tab[op]) return 9'd0;
            return {exe_tab[op], ins[20], 3'b000, wb_tab[op]};
        end
        if (ins[27:26] == 2'b01)
            return ins[20] ? {4'b0010, 5'b00011} : {4'b0010, 5'b00100};
        if (ins[27:26] == 2'b10) return {4'b0000, 5'b01000};
        return 9'd0;
    endfunction

    function automatic logic [31:0] ref_read(input logic [3:0] idx);
        if (int'(idx) >= REGS) return 32'd0;
`ifdef WB_BYPASS_EN
        if (WB_ENIn && WB_DestIn == idx) return WB_ValueIn;
`endif
        return rf_m[idx];
    endfunction

    task automatic set_idle();
        rst = 1'b0; validIn = 1'b0; hazardIn = 1'b0; flushIn = 1'b0; WB_ENIn = 1'b0;
        WB_DestIn = 4'd0; WB_ValueIn = 32'd0; statusIn = 4'd0;
        instructionIn = 32'd0; PCIn = 32'd0;
    endtask

    // One clock: check combinational outputs, clock, check the loaded slot, advance the model
    task automatic run_cycle();
        logic in_flush, is_str, ok;
        logic [3:0] s2;
        logic [8:0] e_ctrl;
        logic e_valid, e_i;
        logic [31:0] e_pc, e_rn, e_rm;
        logic [3:0] e_dest;
        logic [11:0] e_sh;
        logic [23:0] e_imm;
        in_flush = (rem_prev >= 2);
        is_str = (instructionIn[27:26] == 2'b01) && !instructionIn[20];
        s2 = is_str ? instructionIn[15:12] : instructionIn[3:0];
        #1;
        chk("src1", {28'd0, src1Out}, {28'd0, instructionIn[19:16]});
        chk("src2", {28'd0, src2Out}, {28'd0, s2});
        chk("two_src", {31'd0, Two_srcOut}, {31'd0, (!instructionIn[25] || is_str)});
        chk("stall", {31'd0, stallOut}, {31'd0, (hazardIn && !in_flush && !flushIn)});
        if (rst || flushIn || in_flush || hazardIn) begin
            e_valid = 1'b0; e_ctrl = 9'd0; e_pc = 32'd0; e_rn = 32'd0; e_rm = 32'd0;
            e_i = 1'b0; e_dest = 4'd0; e_sh = 12'd0; e_imm = 24'd0;
        end else begin
            ok = validIn && ref_cond(instructionIn[31:28], statusIn);
            e_valid = validIn;
            e_ctrl = ok ? ref_ctrl(instructionIn) : 9'd0;
            e_pc = PCIn;
            e_rn = ref_read(instructionIn[19:16]);
            e_rm = ref_read(s2);
            e_i = instructionIn[25];
            e_dest = instructionIn[15:12];
            e_sh = instructionIn[11:0];
            e_imm = instructionIn[23:0];
        end
        @(posedge clk);
        #1;
        chk("valid", {31'd0, validOut}, {31'd0, e_valid});
        chk("ctrl", {23'd0, EXE_CMDOut, SOut, BOut, MEM_W_ENOut, MEM_R_ENOut, WB_ENOut}, {23'd0, e_ctrl});
        chk("pc", PCOut, e_pc);
        chk("val_rn", Val_RnOut, e_rn);
        chk("val_rm", Val_RmOut, e_rm);
        chk("fields", {3'd0, IOut, DestOut, shiftOperandOut}, {3'd0, e_i, e_dest, e_sh});
        chk("imm24", {8'd0, Imm24Out}, {8'd0, e_imm});
        if (rst) begin
            for (int i = 0; i < 16; i++) rf_m[i] = 32'd0;
            rem_prev = 0;
        end else begin
            if (WB_ENIn && int'(WB_DestIn) < REGS) rf_m[WB_DestIn] = WB_ValueIn;
            rem_prev = flushIn ? FC : ((rem_prev > 0) ? rem_prev - 1 : 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            exe_tab[i] = 4'd0; wb_tab[i] = 1'b0; known_tab[i] = 1'b0; rf_m[i] = 32'd0;
        end
        set_op(4'b1101, 4'b0001, 1'b1); set_op(4'b1111, 4'b1001, 1'b1);
        set_op(4'b0100, 4'b0010, 1'b1); set_op(4'b0101, 4'b0011, 1'b1);
        set_op(4'b0010, 4'b0100, 1'b1); set_op(4'b0110, 4'b0101, 1'b1);
        set_op(4'b0000, 4'b0110, 1'b1); set_op(4'b1100, 4'b0111, 1'b1);
        set_op(4'b0001, 4'b1000, 1'b1); set_op(4'b1010, 4'b0100, 1'b0);
        set_op(4'b1000, 4'b0110, 1'b0);

        // Reset
        set_idle(); rst = 1'b1;
        run_cycle(); run_cycle();
        chk("rst_valid", {31'd0, validOut}, 32'd0);
        rst = 1'b0;

        // Preload R2 = 5, R3 = 7
        WB_ENIn = 1'b1; WB_DestIn = 4'd2; WB_ValueIn = 32'd5; run_cycle();
        WB_DestIn = 4'd3; WB_ValueIn = 32'd7; run_cycle();
        WB_ENIn = 1'b0;

        // ADD R1,R2,R3
        validIn = 1'b1; instructionIn = 32'hE0821003; PCIn = 32'h100; run_cycle();
        chk("add_valid", {31'd0, validOut}, 32'd1);
        chk("add_exe", {28'd0, EXE_CMDOut}, 32'd2);
        chk("add_rn", Val_RnOut, 32'd5);
        chk("add_rm", Val_RmOut, 32'd7);
        chk("add_dest", {28'd0, DestOut}, 32'd1);
        chk("add_wb", {31'd0, WB_ENOut}, 32'd1);

        // MOVEQ with Z = 0 fails, with Z = 1 passes
        instructionIn = 32'h01A01002; statusIn = 4'b0000; run_cycle();
        chk("moveq_valid", {31'd0, validOut}, 32'd1);
        chk("moveq_ctrl", {27'd0, EXE_CMDOut, WB_ENOut}, 32'd0);
        statusIn = 4'b0100; run_cycle();
        chk("moveq_pass", {27'd0, EXE_CMDOut, WB_ENOut}, 32'h3);

        // Stall two cycles, then the held instruction goes through
        instructionIn = 32'hE0821003; hazardIn = 1'b1;
        run_cycle(); chk("stall1_valid", {31'd0, validOut}, 32'd0);
        run_cycle(); chk("stall2_valid", {31'd0, validOut}, 32'd0);
        hazardIn = 1'b0; run_cycle();
        chk("held_valid", {31'd0, validOut}, 32'd1);

        // Single flush: three bubbles, hazard ignored while squashing
        flushIn = 1'b1; run_cycle(); chk("fl_b1", {31'd0, validOut}, 32'd0);
        flushIn = 1'b0; hazardIn = 1'b1;
        run_cycle(); chk("fl_b2", {31'd0, validOut}, 32'd0);
        run_cycle(); chk("fl_b3", {31'd0, validOut}, 32'd0);
        hazardIn = 1'b0; run_cycle(); chk("fl_after", {31'd0, validOut}, 32'd1);

        // Flush extended by a second pulse: four bubbles
        flushIn = 1'b1; run_cycle(); run_cycle();
        flushIn = 1'b0;
        run_cycle(); run_cycle(); chk("fl2_b4", {31'd0, validOut}, 32'd0);
        run_cycle(); chk("fl2_after", {31'd0, validOut}, 32'd1);

        // Write-back of R4 while reading R4 (ADD R5,R4,R3)
        instructionIn = 32'hE0845003; WB_ENIn = 1'b1; WB_DestIn = 4'd4; WB_ValueIn = 32'hDEAD;
        run_cycle();
`ifdef WB_BYPASS_EN
        chk("bypass_rn", Val_RnOut, 32'hDEAD);
`else
        chk("bypass_rn", Val_RnOut, 32'd0);
`endif
        WB_ENIn = 1'b0; run_cycle(); chk("after_wb_rn", Val_RnOut, 32'hDEAD);

        // Indices beyond REG_COUNT: write dropped, read returns 0 (ADD R0,R13,R2)
        WB_ENIn = 1'b1; WB_DestIn = 4'd13; WB_ValueIn = 32'h1234; validIn = 1'b0; run_cycle();
        WB_ENIn = 1'b0; validIn = 1'b1; instructionIn = 32'hE08D0002; run_cycle();
        chk("oob_rn", Val_RnOut, 32'd0);

        // Reset while squashing, then normal acceptance
        flushIn = 1'b1; run_cycle();
        flushIn = 1'b0; rst = 1'b1; run_cycle();
        rst = 1'b0; instructionIn = 32'hE0821003; run_cycle();
        chk("post_rst_valid", {31'd0, validOut}, 32'd1);
        chk("post_rst_exe", {28'd0, EXE_CMDOut}, 32'd2);

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            rst = ($urandom_range(0, 99) == 0);
            instructionIn = $urandom();
            PCIn = $urandom();
            validIn = ($urandom_range(0, 9) != 0);
            statusIn = 4'($urandom_range(0, 15));
            hazardIn = ($urandom_range(0, 4) == 0);
            flushIn = ($urandom_range(0, 15) == 0);
            WB_ENIn = ($urandom_range(0, 1) == 1);
            WB_DestIn = 4'($urandom_range(0, 15));
            WB_ValueIn = $urandom();
            run_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
